// File: rtl/spike_mac_accum_if.sv
// rtl/spike_mac_accum_if.sv - handshake and data bundle for spike_mac_accum (fire_spikes present under SPIKE_MAC_FIRE_EN)
interface spike_mac_accum_if #(
  parameter int INPUT_VEC_LEN  = 8,
  parameter int OUTPUT_VEC_LEN = 8,
  parameter int WIDTH          = 8,
  parameter int OUT_WIDTH      = 11
);
  logic                                      clear;
  logic                                      in_valid;
  logic                                      in_ready;
  logic [INPUT_VEC_LEN-1:0]                  in_spikes;
  logic                                      in_last;
  logic [INPUT_VEC_LEN*OUTPUT_VEC_LEN*WIDTH-1:0] weights;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [OUTPUT_VEC_LEN*OUT_WIDTH-1:0]       out_sum;
  logic                                      out_sat;
`ifdef SPIKE_MAC_FIRE_EN
  logic [OUTPUT_VEC_LEN-1:0]                 fire_spikes;

  modport master (
    output clear, in_valid, in_spikes, in_last, weights, out_ready,
    input  in_ready, out_valid, out_sum, out_sat, fire_spikes
  );
  modport slave (
    input  clear, in_valid, in_spikes, in_last, weights, out_ready,
    output in_ready, out_valid, out_sum, out_sat, fire_spikes
  );
`else
  modport master (
    output clear, in_valid, in_spikes, in_last, weights, out_ready,
    input  in_ready, out_valid, out_sum, out_sat
  );
  modport slave (
    input  clear, in_valid, in_spikes, in_last, weights, out_ready,
    output in_ready, out_valid, out_sum, out_sat
  );
`endif
endinterface

// File: rtl/spike_mac_accum.sv
// rtl/spike_mac_accum.sv - row-serial saturating spike x weight accumulator over a frame (optional SPIKE_MAC_FIRE_EN)
module spike_mac_accum #(
  parameter int INPUT_VEC_LEN  = 8,
  parameter int OUTPUT_VEC_LEN = 8,
  parameter int WIDTH          = 8,
  parameter int OUT_WIDTH      = 11,
  parameter int THRESHOLD      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  spike_mac_accum_if.slave   bus
);

  localparam int ROW_W = (INPUT_VEC_LEN > 1) ? $clog2(INPUT_VEC_LEN) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(INPUT_VEC_LEN - 1);
  localparam logic [OUT_WIDTH-1:0] SAT_MAX = {OUT_WIDTH{1'b1}};

  // Reject parameter sets the row-serial datapath cannot handle.
  if (INPUT_VEC_LEN < 2 || OUT_WIDTH < WIDTH || THRESHOLD < 0) begin : g_param_check
    $error("spike_mac_accum: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                   state;
  logic [INPUT_VEC_LEN-1:0] spikes_q;
  logic                     last_q;
  logic [ROW_W-1:0]         row;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic                     out_sat_q;
  logic [OUT_WIDTH-1:0]     acc      [OUTPUT_VEC_LEN];
  logic [OUT_WIDTH-1:0]     acc_next [OUTPUT_VEC_LEN];
  logic [OUT_WIDTH:0]       wsum     [OUTPUT_VEC_LEN];
  logic                     sat_any;

  // One adder per column: add the current row's weight when that row spiked, clipping at full scale.
  always_comb begin
    sat_any = 1'b0;
    for (int j = 0; j < OUTPUT_VEC_LEN; j++) begin
      wsum[j]     = {1'b0, acc[j]}
                  + {{(OUT_WIDTH + 1 - WIDTH){1'b0}},
                     bus.weights[(int'(row) * OUTPUT_VEC_LEN + j) * WIDTH +: WIDTH]};
      acc_next[j] = acc[j];
      if (spikes_q[row]) begin
        if (wsum[j][OUT_WIDTH]) begin
          acc_next[j] = SAT_MAX;
          sat_any     = 1'b1;
        end else begin
          acc_next[j] = wsum[j][OUT_WIDTH-1:0];
        end
      end
    end
  end

  // Frame FSM: accept a vector, scan its rows, then hold the result until downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      spikes_q    <= '0;
      last_q      <= 1'b0;
      row         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      acc         <= '{default: '0};
    end else if (bus.clear) begin
      state       <= IDLE;
      spikes_q    <= '0;
      last_q      <= 1'b0;
      row         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      acc         <= '{default: '0};
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            spikes_q   <= bus.in_spikes;
            last_q     <= bus.in_last;
            row        <= '0;
            in_ready_q <= 1'b0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          acc       <= acc_next;
          out_sat_q <= out_sat_q | sat_any;
          if (row == LAST_ROW) begin
            row <= '0;
            if (last_q) begin
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              in_ready_q <= 1'b1;
              state      <= IDLE;
            end
          end else begin
            row <= row + ROW_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            acc         <= '{default: '0};
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sat   = out_sat_q;

  for (genvar j = 0; j < OUTPUT_VEC_LEN; j++) begin : g_out
    assign bus.out_sum[j*OUT_WIDTH +: OUT_WIDTH] = acc[j];
`ifdef SPIKE_MAC_FIRE_EN
    assign bus.fire_spikes[j] = out_valid_q && (int'(acc[j]) >= THRESHOLD);
`endif
  end

endmodule

// File: tb/tb_spike_mac_accum.sv
// tb/tb_spike_mac_accum.sv - directed self-checking bench for spike_mac_accum
module tb_spike_mac_accum;
  localparam int N  = 8;
  localparam int M  = 8;
  localparam int W  = 8;
  localparam int OW = 11;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  spike_mac_accum_if #(.INPUT_VEC_LEN(N), .OUTPUT_VEC_LEN(M), .WIDTH(W), .OUT_WIDTH(OW)) bus ();

  spike_mac_accum #(
    .INPUT_VEC_LEN(N), .OUTPUT_VEC_LEN(M), .WIDTH(W), .OUT_WIDTH(OW), .THRESHOLD(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expect out_sum[j] == base + stride*j for every column.
  task automatic check_all(input string tag, input int base, input int stride);
    logic [OW-1:0] v;
    for (int j = 0; j < M; j++) begin
      v = bus.out_sum[j*OW +: OW];
      chk($sformatf("%s_col%0d", tag, j), 64'(v), 64'(base + stride * j));
    end
  endtask

  task automatic set_weights_const(input int val);
    for (int r = 0; r < N; r++)
      for (int j = 0; j < M; j++)
        bus.weights[(r*M + j)*W +: W] = W'(val);
  endtask

  task automatic set_weights_ramp();
    for (int r = 0; r < N; r++)
      for (int j = 0; j < M; j++)
        bus.weights[(r*M + j)*W +: W] = W'(8*r + j);
  endtask

  task automatic send_vec(input logic [N-1:0] sp, input logic last);
    int n;
    n = 0;
    bus.in_valid  = 1'b1;
    bus.in_spikes = sp;
    bus.in_last   = last;
    while (!bus.in_ready && n < 40) begin
      step();
      n++;
    end
    chk("accept_wait", 64'(n < 40), 64'(1));
    step();
    bus.in_valid = 1'b0;
    chk("in_ready_after_accept", 64'(bus.in_ready), 64'(0));
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(N));
  endtask

  task automatic collect();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("post_handshake_valid", 64'(bus.out_valid), 64'(0));
    chk("post_handshake_ready", 64'(bus.in_ready), 64'(1));
    chk("post_handshake_sat", 64'(bus.out_sat), 64'(0));
    check_all("post_handshake_sum", 0, 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_spikes = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    bus.weights   = '0;
    step();
    step();
    chk("reset_valid", 64'(bus.out_valid), 64'(0));
    chk("reset_ready", 64'(bus.in_ready), 64'(1));
    chk("reset_sat", 64'(bus.out_sat), 64'(0));
    check_all("reset_sum", 0, 0);
    rst_n = 1'b1;
    step();

    // Test 1: single step, all spikes, unit weights.
    set_weights_const(1);
    send_vec(8'hFF, 1'b1);
    wait_out("t1");
    check_all("t1_sum", 8, 0);
    chk("t1_sat", 64'(bus.out_sat), 64'(0));
    collect();

    // Test 2: sparse spikes on rows 0 and 2 with ramp weights.
    set_weights_ramp();
    send_vec(8'b0000_0101, 1'b1);
    wait_out("t2");
    check_all("t2_sum", 16, 2);
`ifdef SPIKE_MAC_FIRE_EN
    chk("t2_fire", 64'(bus.fire_spikes), 64'(8'b1111_1100));
`endif
    collect();
`ifdef SPIKE_MAC_FIRE_EN
    chk("t2_fire_idle", 64'(bus.fire_spikes), 64'(0));
`endif

    // Zero spike vector still scans the full frame.
    send_vec(8'h00, 1'b1);
    wait_out("zero");
    check_all("zero_sum", 0, 0);
    collect();

    // Test 3: saturation across a three-step frame.
    set_weights_const(255);
    send_vec(8'hFF, 1'b0);
    for (int i = 0; i < N; i++) step();
    chk("t3_mid_valid", 64'(bus.out_valid), 64'(0));
    chk("t3_mid_ready", 64'(bus.in_ready), 64'(1));
    chk("t3_mid_sat", 64'(bus.out_sat), 64'(0));
    check_all("t3_step1_sum", 2040, 0);
    send_vec(8'hFF, 1'b0);
    for (int i = 0; i < N; i++) step();
    chk("t3_step2_sat", 64'(bus.out_sat), 64'(1));
    send_vec(8'hFF, 1'b1);
    wait_out("t3");
    check_all("t3_sum", 2047, 0);
    chk("t3_sat", 64'(bus.out_sat), 64'(1));
    collect();
    set_weights_const(1);
    send_vec(8'hFF, 1'b1);
    wait_out("t3_next");
    check_all("t3_next_sum", 8, 0);
    chk("t3_next_sat", 64'(bus.out_sat), 64'(0));
    collect();

    // Test 4: backpressure with a pending vector held by upstream.
    send_vec(8'hFF, 1'b1);
    wait_out("t4");
    bus.in_valid  = 1'b1;
    bus.in_spikes = 8'h0F;
    bus.in_last   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_valid", 64'(bus.out_valid), 64'(1));
      chk("t4_hold_ready", 64'(bus.in_ready), 64'(0));
      chk("t4_hold_sum0", 64'(bus.out_sum[0 +: OW]), 64'(8));
    end
    check_all("t4_hold_sum", 8, 0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("t4_hs_valid", 64'(bus.out_valid), 64'(0));
    chk("t4_hs_ready", 64'(bus.in_ready), 64'(1));
    step();
    bus.in_valid = 1'b0;
    chk("t4_accept_next", 64'(bus.in_ready), 64'(0));
    wait_out("t4_next");
    check_all("t4_next_sum", 4, 0);
    collect();

    // Test 5a: asynchronous reset during row 3 of a scan.
    send_vec(8'hFF, 1'b1);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(bus.out_valid), 64'(0));
    chk("t5_rst_ready", 64'(bus.in_ready), 64'(1));
    check_all("t5_rst_sum", 0, 0);
    step();
    rst_n = 1'b1;
    step();
    set_weights_ramp();
    send_vec(8'b0000_0101, 1'b1);
    wait_out("t5_rst_next");
    check_all("t5_rst_next_sum", 16, 2);
    collect();

    // Test 5b: clear while holding a result.
    set_weights_const(1);
    send_vec(8'hFF, 1'b1);
    wait_out("t5_clr");
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("t5_clr_valid", 64'(bus.out_valid), 64'(0));
    chk("t5_clr_ready", 64'(bus.in_ready), 64'(1));
    check_all("t5_clr_sum", 0, 0);
    send_vec(8'hFF, 1'b1);
    wait_out("t5_clr_next");
    check_all("t5_clr_next_sum", 8, 0);
    collect();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
